// File: rtl/mult_fu.sv
// Pipelined integer multiplier for the MUL/MULH/MULHSU/MULHU ops. Each stage folds one
// XLEN/NUM_STAGES-bit slice of the multiplier into a 2*XLEN accumulator; the whole pipe stalls on a CDB back-pressure.
package mult_fu_pkg;
  typedef enum logic [1:0] {
    ALU_MUL    = 2'd0,
    ALU_MULH   = 2'd1,
    ALU_MULHSU = 2'd2,
    ALU_MULHU  = 2'd3
  } ALU_FUNC;
endpackage

module mult_fu_stage
  import mult_fu_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int CW             = 8,
  parameter int IDX            = 0,
  parameter int PREG_IDX_WIDTH = 6
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      i_en,
  input  logic [2*XLEN-1:0]         i_a,
  input  logic [XLEN-1:0]           i_b,
  input  logic [2*XLEN-1:0]         i_acc,
  input  ALU_FUNC                   i_func,
  input  logic [PREG_IDX_WIDTH-1:0] i_tag,
  output logic [2*XLEN-1:0]         o_a,
  output logic [XLEN-1:0]           o_b,
  output logic [2*XLEN-1:0]         o_acc,
  output ALU_FUNC                   o_func,
  output logic [PREG_IDX_WIDTH-1:0] o_tag
);
  logic [2*XLEN-1:0] w_chunk, w_part;

  assign w_chunk = {{(2*XLEN-CW){1'b0}}, i_b[IDX*CW +: CW]};
  assign w_part  = (i_a * w_chunk) << (IDX*CW);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      o_a    <= '0;
      o_b    <= '0;
      o_acc  <= '0;
      o_func <= ALU_MUL;
      o_tag  <= '0;
    end else if (i_en) begin
      o_a    <= i_a;
      o_b    <= i_b;
      o_acc  <= i_acc + w_part;
      o_func <= i_func;
      o_tag  <= i_tag;
    end
  end
endmodule

module mult_fu
  import mult_fu_pkg::*;
#(
  parameter int NUM_STAGES     = 4,
  parameter int XLEN           = 32,
  parameter int PREG_IDX_WIDTH = 6
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic [XLEN-1:0]           opa,
  input  logic [XLEN-1:0]           opb,
  input  ALU_FUNC                   func,
  input  logic [PREG_IDX_WIDTH-1:0] pdest_idx_in,
  input  logic                      squash,
  input  logic                      cdb_grant,
  output logic                      mult_ready,
  output logic                      result_valid,
  output logic [XLEN-1:0]           result,
  output logic [PREG_IDX_WIDTH-1:0] pdest_idx_out
);
  localparam int CW = XLEN / NUM_STAGES;
  localparam int W2 = 2 * XLEN;

  logic [NUM_STAGES:0][W2-1:0]             w_a, w_acc;
  logic [NUM_STAGES:0][XLEN-1:0]           w_b;
  logic [NUM_STAGES:0][PREG_IDX_WIDTH-1:0] w_tag;
  ALU_FUNC                                 w_func [NUM_STAGES+1];
  logic [NUM_STAGES-1:0]                   r_vld;
  logic                                    w_stall, w_adv, w_a_sgn;
  logic                                    w_unused;

  assign w_stall = result_valid && !cdb_grant;
  assign w_adv   = !w_stall;

  assign w_a_sgn   = (func == ALU_MULH) || (func == ALU_MULHSU);
  assign w_a[0]    = w_a_sgn ? {{XLEN{opa[XLEN-1]}}, opa} : {{XLEN{1'b0}}, opa};
  assign w_b[0]    = opb;
  assign w_func[0] = func;
  assign w_tag[0]  = pdest_idx_in;
  // Slices treat opb as unsigned; a negative signed multiplier is corrected up front by -(a << XLEN).
  assign w_acc[0]  = (func == ALU_MULH && opb[XLEN-1]) ?
                     ({W2{1'b0}} - {w_a[0][XLEN-1:0], {XLEN{1'b0}}}) : '0;

  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
    mult_fu_stage #(
      .XLEN(XLEN), .CW(CW), .IDX(g), .PREG_IDX_WIDTH(PREG_IDX_WIDTH)
    ) u_stage (
      .clock (clock),
      .reset (reset),
      .i_en  (w_adv),
      .i_a   (w_a[g]),
      .i_b   (w_b[g]),
      .i_acc (w_acc[g]),
      .i_func(w_func[g]),
      .i_tag (w_tag[g]),
      .o_a   (w_a[g+1]),
      .o_b   (w_b[g+1]),
      .o_acc (w_acc[g+1]),
      .o_func(w_func[g+1]),
      .o_tag (w_tag[g+1])
    );
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_vld <= '0;
    end else if (squash) begin
      r_vld <= '0;
    end else if (w_adv) begin
      r_vld[0] <= start;
      for (int i = 1; i < NUM_STAGES; i++) r_vld[i] <= r_vld[i-1];
    end
  end

  assign result_valid  = r_vld[NUM_STAGES-1];
  assign mult_ready    = !w_stall;
  assign result        = (w_func[NUM_STAGES] == ALU_MUL) ? w_acc[NUM_STAGES][XLEN-1:0]
                                                         : w_acc[NUM_STAGES][W2-1:XLEN];
  assign pdest_idx_out = w_tag[NUM_STAGES];
  assign w_unused      = ^{w_a[NUM_STAGES], w_b[NUM_STAGES]};
endmodule
